axi_traffic_checker: RTL and testbench
======================================

// Module: axi_traffic_checker
// PURPOSE
//  AXI4 write-then-readback memory tester, parametrised in width, burst length, address window and pattern.
//  Writes one INCR burst, reads the same burst back, compares every beat, then advances; counts beats and mismatches.
//  Sits as an AXI4 master in memory-subsystem benches/bring-up, e.g. in front of the DDR slave wrapper.
// PARAMETERS
//  DATA_WIDTH     128           data bus width; power of 2, 32..512
//  ADDR_WIDTH     32            address width
//  ID_WIDTH       8             AXI ID width
//  ID             4             value driven on awid/arid
//  BURST_LEN      16            beats per burst, 1..256 (awlen = arlen = BURST_LEN-1)
//  START_ADDR     32'h0000_0000 first burst address; aligned to burst byte size
//  STOP_ADDR      32'h0000_1000 exclusive end of test window
//  STOP_WHEN_FAIL 1'b1          1: go to DONE after the first failing burst
// PORTS
//  clk            in  1     clock
//  rst_n          in  1     reset, asynchronous, active-high
//  start          in  1     rising-edge pulse; starts a pass from IDLE/DONE
//  loop_en        in  1     1: wrap to START_ADDR at end of window instead of DONE
//  pattern_sel    in  2     0 LFSR, 1 address-incrementing, 2 walking-ones, 3 inverted LFSR
//  busy           out 1     high from start accepted until DONE
//  done           out 1     high in DONE
//  fail           out 1     sticky; set on any mismatch or non-OKAY bresp/rresp
//  total_beats    out 32    beats read and compared, saturating
//  fail_count     out 32    mismatching beats, saturating
//  aw*/w*/b*      AXI4 write channels (id,addr,len,size,burst,lock,cache,prot,qos,region,valid/ready,data,strb,last,resp)
//  ar*/r*         AXI4 read channels, same field set
// BEHAVIOUR
//  Reset: all outputs 0, all valids 0, state IDLE, addr=START_ADDR. Constant fields: awsize/arsize=log2(DATA_WIDTH/8),
//   burst=INCR(2'b01), lock/cache/prot/qos/region=0, wstrb all ones, bready=rready=1 in their wait states only.
//  FSM: IDLE -start-> AW -awready-> W -last beat accepted-> B -bvalid-> AR -arready-> R -rlast accepted-> NEXT.
//  NEXT: addr += BURST_LEN*DATA_WIDTH/8; if fail&&STOP_WHEN_FAIL -> DONE; else if new addr>=STOP_ADDR:
//   loop_en ? addr=START_ADDR, -> AW : -> DONE; else -> AW. NEXT lasts exactly one cycle.
//  DONE -start-> AW (counters and fail cleared, addr=START_ADDR). start ignored while busy.
//  Valid held until ready; payload stable while valid&&!ready. One outstanding transaction total.
//  wvalid asserted the cycle after AW handshake; wlast on beat BURST_LEN-1; one beat per wvalid&&wready.
//  Pattern: generator seeded from burst address at AW and again at AR entry; beat n of the read regenerates
//   beat n of the write. LFSR seed 0 is forced to 1. Generator advances only on handshake.
//  Compare in R on rvalid&&rready: total_beats++; mismatch or rresp!=0 -> fail_count++, fail=1. bresp!=0 -> fail=1,
//   fail_count unchanged. Counters saturate at 32'hFFFF_FFFF.
//  rlast early/late vs beat count: treat as failure (fail=1); R exits on rlast.
//  pattern_sel sampled at AW entry and held for that burst's write and read.
//  Async reset mid-burst: immediate return to reset state; no attempt to finish the AXI transfer.
// CONFIGURATION
//  ERR_CAPTURE_EN defined: extra outputs err_addr[ADDR_WIDTH], err_exp[DATA_WIDTH], err_act[DATA_WIDTH]
//   latch address/expected/actual of the FIRST failing read beat; cleared on reset and on start.
//  Not defined: those ports and registers absent; all other behaviour identical.
// STRUCTURE
//  Package axi_tc_pkg: state enum (IDLE,AW,W,B,AR,R,NEXT,DONE), pattern enum, AXI burst/resp constants.
//  Sub-module tc_pattern_gen (DATA_WIDTH, load, seed, advance, mode -> data): instantiated twice (write, read).
// TESTING
//  Ideal slave, pattern 0, BURST_LEN=16, window 0..0x1000 -> 16 bursts, total_beats=256, fail=0, done=1.
//  Slave flips bit 0 of rdata at addr 0x200 beat 3 -> fail=1, fail_count=1, DONE after that burst (STOP_WHEN_FAIL=1).
//  Random awready/wready/arready/rvalid stalls (50%) -> valid/payload stable while stalled, result identical to ideal.
//  loop_en=1, window 0..0x200 -> addr wraps to 0 after 0x1F0 burst, done stays 0, total_beats keeps rising.
//  bresp=SLVERR on first burst -> fail=1, fail_count=0; ERR_CAPTURE_EN: err_addr=0x340 for mismatch injected at 0x340.
//  rst_n pulsed mid-W phase -> all valids 0 next edge, state IDLE, counters 0; start afterwards runs clean pass.

Source files
------------

// File: rtl/axi_tc_pkg.sv
// Shared types and constants for the AXI4 write/readback traffic checker.
// Optional error capture is enabled with the ERR_CAPTURE_EN macro (see top).
package axi_tc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_NEXT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        PAT_LFSR,
        PAT_INC,
        PAT_WALK,
        PAT_INV
    } pattern_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // Galois step; the mask has bit 31 set so a non-zero state never reaches 0
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/tc_pattern_gen.sv
// Data pattern generator: seeded from a burst address, steps once per beat.
// Two instances (write side, read side) produce identical beat sequences.
module tc_pattern_gen
    import axi_tc_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [31:0]           seed,
    input  logic                  advance,
    input  pattern_e              mode,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int LANES = DATA_WIDTH / 32;
    localparam int LOG_B = $clog2(DATA_WIDTH / 8);
    localparam int LOG_DW = $clog2(DATA_WIDTH);

    logic [31:0]           r_lfsr;
    logic [31:0]           r_cnt;
    logic [DATA_WIDTH-1:0] w_rep;
    logic [DATA_WIDTH-1:0] w_inc;
    logic [DATA_WIDTH-1:0] w_walk;
    logic [LOG_DW-1:0]     w_pos;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_lfsr <= 32'd1;
            r_cnt  <= '0;
        end else if (load) begin
            r_lfsr <= (seed == 32'd0) ? 32'd1 : seed;
            r_cnt  <= seed;
        end else if (advance) begin
            r_lfsr <= lfsr_next(r_lfsr);
            r_cnt  <= r_cnt + 32'(DATA_WIDTH / 8);
        end
    end

    // r_cnt tracks the byte address of the current beat
    assign w_pos = r_cnt[LOG_B +: LOG_DW];
    assign w_rep = {LANES{r_lfsr}};

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            w_inc[i*32 +: 32] = r_cnt + 32'(i * 4);
        end
        w_walk = '0;
        w_walk[w_pos] = 1'b1;
        data = '0;
        unique case (mode)
            PAT_LFSR: data = w_rep;
            PAT_INC:  data = w_inc;
            PAT_WALK: data = w_walk;
            PAT_INV:  data = ~w_rep;
            default:  data = w_rep;
        endcase
    end

endmodule

// File: rtl/axi_traffic_checker.sv
// AXI4 master that writes one INCR burst, reads it back and compares.
// Define ERR_CAPTURE_EN to add err_addr/err_exp/err_act first-failure capture.
module axi_traffic_checker
    import axi_tc_pkg::*;
#(
    parameter int              DATA_WIDTH     = 128,
    parameter int              ADDR_WIDTH     = 32,
    parameter int              ID_WIDTH       = 8,
    parameter int              ID             = 4,
    parameter int              BURST_LEN      = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] STOP_ADDR  = 32'h0000_1000,
    parameter bit              STOP_WHEN_FAIL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    loop_en,
    input  logic [1:0]              pattern_sel,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [31:0]             total_beats,
    output logic [31:0]             fail_count,
`ifdef ERR_CAPTURE_EN
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic [DATA_WIDTH-1:0]   err_exp,
    output logic [DATA_WIDTH-1:0]   err_act,
`endif
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic [3:0]              awqos,
    output logic [3:0]              awregion,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic [3:0]              arqos,
    output logic [3:0]              arregion,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int LOG_BYTES   = $clog2(BEAT_BYTES);
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);

    state_e                r_state;
    state_e                w_next;
    pattern_e              r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_aw_addr;
    logic [ADDR_WIDTH:0]   w_sum;
    logic [8:0]            r_beat;
    logic                  r_fail;
    logic                  r_start_d;
    logic [31:0]           r_total;
    logic [31:0]           r_fail_cnt;
    logic                  w_start_rise;
    logic                  w_clear;
    logic                  w_enter_aw;
    logic                  w_enter_ar;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_rd_bad;
    logic                  w_last_err;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0] w_rd_exp;

    assign w_start_rise = start & ~r_start_d;
    assign w_w_hs       = (r_state == S_W) & wready;
    assign w_r_hs       = (r_state == S_R) & rvalid;
    assign w_rd_bad     = (rdata != w_rd_exp) | (rresp != RESP_OKAY);
    assign w_last_err   = rlast ^ (r_beat == LAST_BEAT);
    assign w_sum        = {1'b0, r_addr} + (ADDR_WIDTH+1)'(BURST_BYTES);

    always_comb begin
        w_next    = r_state;
        w_aw_addr = START_ADDR;
        w_clear   = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_rise) begin
                    w_next  = S_AW;
                    w_clear = 1'b1;
                end
            end
            S_AW: if (awready) w_next = S_W;
            S_W:  if (wready && r_beat == LAST_BEAT) w_next = S_B;
            S_B:  if (bvalid) w_next = S_AR;
            S_AR: if (arready) w_next = S_R;
            S_R:  if (rvalid && rlast) w_next = S_NEXT;
            S_NEXT: begin
                if (r_fail && STOP_WHEN_FAIL) begin
                    w_next = S_DONE;
                end else if (w_sum >= {1'b0, STOP_ADDR}) begin
                    w_next = loop_en ? S_AW : S_DONE;
                end else begin
                    w_next    = S_AW;
                    w_aw_addr = w_sum[ADDR_WIDTH-1:0];
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_aw = (w_next == S_AW) && (r_state != S_AW);
    assign w_enter_ar = (r_state == S_B) && bvalid;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= PAT_LFSR;
            r_addr     <= START_ADDR;
            r_beat     <= '0;
            r_fail     <= 1'b0;
            r_start_d  <= 1'b0;
            r_total    <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_start_d <= start;
            if (r_state == S_NEXT) r_addr <= w_sum[ADDR_WIDTH-1:0];
            if (w_enter_aw) begin
                r_addr <= w_aw_addr;
                r_mode <= pattern_e'(pattern_sel);
                r_beat <= '0;
            end
            if (w_clear) begin
                r_fail     <= 1'b0;
                r_total    <= '0;
                r_fail_cnt <= '0;
            end
            if (w_w_hs) r_beat <= r_beat + 9'd1;
            if (w_enter_ar) r_beat <= '0;
            if (w_enter_ar && bresp != RESP_OKAY) r_fail <= 1'b1;
            if (w_r_hs) begin
                r_beat <= r_beat + 9'd1;
                if (r_total != '1) r_total <= r_total + 32'd1;
                if (w_rd_bad) begin
                    r_fail <= 1'b1;
                    if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 32'd1;
                end
                if (w_last_err) r_fail <= 1'b1;
            end
        end
    end

`ifdef ERR_CAPTURE_EN
    logic                  r_err_hit;
    logic [ADDR_WIDTH-1:0] r_err_addr;
    logic [DATA_WIDTH-1:0] r_err_exp;
    logic [DATA_WIDTH-1:0] r_err_act;
    logic [ADDR_WIDTH-1:0] w_beat_addr;

    assign w_beat_addr = r_addr + (ADDR_WIDTH'(r_beat) << LOG_BYTES);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_err_hit  <= 1'b0;
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_act  <= '0;
        end else if (w_clear) begin
            r_err_hit  <= 1'b0;
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_act  <= '0;
        end else if (w_r_hs && w_rd_bad && !r_err_hit) begin
            r_err_hit  <= 1'b1;
            r_err_addr <= w_beat_addr;
            r_err_exp  <= w_rd_exp;
            r_err_act  <= rdata;
        end
    end

    assign err_addr = r_err_addr;
    assign err_exp  = r_err_exp;
    assign err_act  = r_err_act;
`endif

    tc_pattern_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_enter_aw),
        .seed    (32'(w_aw_addr)),
        .advance (w_w_hs),
        .mode    (r_mode),
        .data    (w_wr_data)
    );

    tc_pattern_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_enter_ar),
        .seed    (32'(r_addr)),
        .advance (w_r_hs),
        .mode    (r_mode),
        .data    (w_rd_exp)
    );

    assign awid     = ID_WIDTH'(ID);
    assign awaddr   = (r_state == S_AW) ? r_addr : '0;
    assign awlen    = 8'(BURST_LEN - 1);
    assign awsize   = 3'(LOG_BYTES);
    assign awburst  = BURST_INCR;
    assign awlock   = 1'b0;
    assign awcache  = 4'd0;
    assign awprot   = 3'd0;
    assign awqos    = 4'd0;
    assign awregion = 4'd0;
    assign awvalid  = (r_state == S_AW);
    assign wdata    = (r_state == S_W) ? w_wr_data : '0;
    assign wstrb    = '1;
    assign wlast    = (r_state == S_W) && (r_beat == LAST_BEAT);
    assign wvalid   = (r_state == S_W);
    assign bready   = (r_state == S_B);
    assign arid     = ID_WIDTH'(ID);
    assign araddr   = (r_state == S_AR) ? r_addr : '0;
    assign arlen    = 8'(BURST_LEN - 1);
    assign arsize   = 3'(LOG_BYTES);
    assign arburst  = BURST_INCR;
    assign arlock   = 1'b0;
    assign arcache  = 4'd0;
    assign arprot   = 3'd0;
    assign arqos    = 4'd0;
    assign arregion = 4'd0;
    assign arvalid  = (r_state == S_AR);
    assign rready   = (r_state == S_R);

    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);
    assign fail        = r_fail;
    assign total_beats = r_total;
    assign fail_count  = r_fail_cnt;

endmodule

// File: tb/tb_axi_traffic_checker.sv
// Randomised bench for axi_traffic_checker: AXI slave model with memory,
// stall/error injection and a beat-level pattern reference model.
module tb_axi_traffic_checker;

    localparam int BL = 16;
    localparam logic [31:0] STOP = 32'h1000;

    logic         clk = 1'b0;
    logic         rst_n, start, loop_en;
    logic [1:0]   pattern_sel;
    logic         busy, done, fail;
    logic [31:0]  total_beats, fail_count;
`ifdef ERR_CAPTURE_EN
    logic [31:0]  err_addr;
    logic [127:0] err_exp, err_act;
`endif
    logic [7:0]   awid, arid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize, awprot, arprot;
    logic [1:0]   awburst, arburst;
    logic         awlock, arlock;
    logic [3:0]   awcache, arcache, awqos, arqos, awregion, arregion;
    logic         awvalid, awready, wvalid, wready, wlast;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready, arvalid, arready;
    logic         rlast, rvalid, rready;

    always #5 clk = ~clk;

    axi_traffic_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en),
        .pattern_sel(pattern_sel), .busy(busy), .done(done), .fail(fail),
        .total_beats(total_beats), .fail_count(fail_count),
`ifdef ERR_CAPTURE_EN
        .err_addr(err_addr), .err_exp(err_exp), .err_act(err_act),
`endif
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awqos(awqos), .awregion(awregion),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arqos(arqos), .arregion(arregion),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected beat n of a burst at base, from the pattern definitions
    function automatic logic [127:0] ref_beat(int mode, logic [31:0] base,
                                              int n);
        logic [127:0] d;
        logic [31:0]  s;
        d = '0;
        s = (base == 32'd0) ? 32'd1 : base;
        if (mode == 0 || mode == 3) begin
            for (int k = 0; k < n; k++)
                s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
            d = {4{s}};
            if (mode == 3) d = ~d;
        end else if (mode == 1) begin
            for (int i = 0; i < 4; i++)
                d[i*32 +: 32] = base + 32'(n * 16) + 32'(i * 4);
        end else begin
            d[((base >> 4) + 32'(n)) % 128] = 1'b1;
        end
        return d;
    endfunction

    // Controls owned by the stimulus process
    bit          stall_en = 0;
    bit          inj_flip = 0;
    logic [31:0] flip_addr = 32'h0;
    bit          inj_bresp = 0;

    // Slave / model state owned by the slave process
    logic [127:0] mem [int unsigned];
    int           aw_cnt = 0;
    int           cur_mode = 0;
    int           w_beat = 0;
    int           r_rem = 0;
    int           stab_err = 0;
    int           proto_err = 0;
    logic [31:0]  exp_aw = 0;
    logic [31:0]  cur_base = 0;
    logic [31:0]  r_a = 0;
    logic [1:0]   b_resp_v = 0;
    bit           b_pend = 0, r_fire = 0, const_done = 0;
    bit           p_aw = 0, p_w = 0, p_ar = 0, p_wlast = 0;
    logic [31:0]  p_awaddr = 0, p_araddr = 0;
    logic [127:0] p_wdata = 0;

    function automatic logic rnd();
        return stall_en ? logic'($urandom_range(0, 1)) : 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            awready = 0; wready = 0; arready = 0;
            bvalid = 0; bresp = 0;
            rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
            b_pend = 0; r_rem = 0; r_fire = 0;
            p_aw = 0; p_w = 0; p_ar = 0;
        end else begin
            if (start) begin
                exp_aw = 0; aw_cnt = 0; cur_mode = int'(pattern_sel);
            end
            if (p_aw && (!awvalid || awaddr !== p_awaddr)) stab_err++;
            if (p_w && (!wvalid || wdata !== p_wdata || wlast !== p_wlast))
                stab_err++;
            if (p_ar && (!arvalid || araddr !== p_araddr)) stab_err++;
            if (r_fire) begin
                rvalid = 0; rlast = 0; r_fire = 0;
            end
            awready = rnd();
            wready  = rnd();
            arready = rnd();
            bvalid  = b_pend;
            bresp   = b_pend ? b_resp_v : 2'b00;
            if (!rvalid && r_rem > 0 && rnd()) begin
                rvalid = 1;
                rdata  = mem.exists(r_a) ? mem[r_a] : '0;
                if (inj_flip && r_a == flip_addr) rdata[0] = ~rdata[0];
                rresp  = 0;
                rlast  = (r_rem == 1);
            end
            if (awvalid && awready) begin
                if (!const_done) begin
                    check("awlen", awlen, BL - 1);
                    check("awsize", awsize, 4);
                    check("awburst", awburst, 1);
                    check("awid", awid, 4);
                    const_done = 1;
                end
                check("awaddr", awaddr, exp_aw);
                cur_base = exp_aw;
                exp_aw = exp_aw + 32'h100;
                if (exp_aw >= STOP) exp_aw = 0;
                aw_cnt++;
                w_beat = 0;
            end
            if (wvalid && wready) begin
                check("wdata", wdata, ref_beat(cur_mode, cur_base, w_beat));
                if (wlast !== (w_beat == BL - 1)) proto_err++;
                mem[cur_base + 32'(w_beat * 16)] = wdata;
                w_beat++;
                if (wlast) begin
                    b_pend = 1;
                    b_resp_v = (inj_bresp && aw_cnt == 1) ? 2'b10 : 2'b00;
                end
            end
            if (bvalid && bready) b_pend = 0;
            if (arvalid && arready) begin
                r_rem = BL;
                r_a = araddr;
                if (araddr !== cur_base) proto_err++;
            end
            if (rvalid && rready) begin
                r_rem--;
                r_a = r_a + 32'd16;
                r_fire = 1;
            end
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w = wvalid && !wready; p_wdata = wdata; p_wlast = wlast;
            p_ar = arvalid && !arready; p_araddr = araddr;
        end
    end

    task automatic kick(int mode);
        @(negedge clk); #1;
        pattern_sel = 2'(mode);
        start = 1;
        @(negedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(string tag);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic run_pass(string tag, int mode);
        kick(mode);
        wait_done(tag);
    endtask

    task automatic expect_end(string tag, int tot, int fcnt, bit f,
                              int bursts);
        check({tag, "_total"}, total_beats, tot);
        check({tag, "_failcnt"}, fail_count, fcnt);
        check({tag, "_fail"}, fail, f);
        check({tag, "_bursts"}, aw_cnt, bursts);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst_n = 1; start = 0; loop_en = 0; pattern_sel = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_total", total_beats, 0);
        check("rst_failcnt", fail_count, 0);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        #1 rst_n = 0;

        run_pass("ideal", 0);
        expect_end("ideal", 256, 0, 0, 16);

        stall_en = 1;
        for (int m = 1; m < 4; m++) begin
            run_pass($sformatf("stall%0d", m), m);
            expect_end($sformatf("stall%0d", m), 256, 0, 0, 16);
        end
        run_pass("stall0", 0);
        expect_end("stall0", 256, 0, 0, 16);

        inj_flip = 1; flip_addr = 32'h230;
        run_pass("flip", 0);
        expect_end("flip", 48, 1, 1, 3);
`ifdef ERR_CAPTURE_EN
        check("err_addr", err_addr, 32'h230);
        check("err_diff", err_exp ^ err_act, 1);
`endif
        inj_flip = 0;

        stall_en = 0; inj_bresp = 1;
        run_pass("bresp", 3);
        expect_end("bresp", 16, 0, 1, 1);
        inj_bresp = 0;

        loop_en = 1;
        kick(1);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (total_beats >= 300) break;
        end
        check("loop_reach", total_beats >= 300, 1);
        check("loop_done", done, 0);
        check("loop_busy", busy, 1);
        check("loop_wrap", aw_cnt > 16, 1);
        #1 loop_en = 0;
        wait_done("loop");
        expect_end("loop", 512, 0, 0, 32);

        stall_en = 1;
        kick(1);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wvalid) break;
        end
        check("midw_reach", wvalid, 1);
        #1 rst_n = 1;
        #1;
        check("midw_valids", {awvalid, wvalid, arvalid}, 0);
        check("midw_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("midw_total", total_beats, 0);
        check("midw_done", done, 0);
        #1 rst_n = 0;
        stall_en = 0;
        run_pass("after", 2);
        expect_end("after", 256, 0, 0, 16);

        check("stable", stab_err, 0);
        check("proto", proto_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
